// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/control engine in front of the datapath ALU.
// Sequence per instruction: IDLE (accept) -> READ -> EXEC -> WB.
// Optional feature macro: ALU_SEQ_MOVI_EN (opcode 10 decodes as MOVI, sign-extended 7-bit immediate).
module alu_issue_ctrl #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [4:0]  IDLE_OP  = 5'b11111,
  localparam int unsigned DW = 16,
  localparam int unsigned AW = 4,
  localparam int unsigned OW = 5,
  localparam int unsigned FW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_rsrc,
  output logic [DW-1:0] alu_rdest,
  output logic [OW-1:0] alu_opcode,
  input  logic [DW-1:0] alu_out,
  input  logic [FW-1:0] alu_flags,
  output logic [FW-1:0] psr,
  output logic          done,
  output logic          illegal,
  input  logic [3:0]    cond,
  output logic          cond_met,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned FLG_C = 0;
  localparam int unsigned FLG_L = 1;
  localparam int unsigned FLG_F = 2;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 4;

  localparam logic [OW-1:0] OP_ADD  = 5'd0;
  localparam logic [OW-1:0] OP_SUB  = 5'd1;
  localparam logic [OW-1:0] OP_CMP  = 5'd2;
  localparam logic [OW-1:0] OP_AND  = 5'd3;
  localparam logic [OW-1:0] OP_OR   = 5'd4;
  localparam logic [OW-1:0] OP_XOR  = 5'd5;
  localparam logic [OW-1:0] OP_NOT  = 5'd6;
  localparam logic [OW-1:0] OP_LSH  = 5'd7;
  localparam logic [OW-1:0] OP_RSH  = 5'd8;
  localparam logic [OW-1:0] OP_ARSH = 5'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_regs [NUM_REGS];
  logic [OW-1:0]   r_op;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_rs;
  logic [DW-1:0]   r_result;
  logic [FW-1:0]   r_flag_cap;
  logic            w_accept;
  logic            w_movi;
  logic            w_wr_en;
  logic            w_psr_all;
  logic            w_psr_cmp;
  logic            w_illegal;

`ifdef ALU_SEQ_MOVI_EN
  localparam logic [OW-1:0] OP_MOVI = 5'd10;
  logic [6:0]      r_imm;
  assign w_movi = (r_op == OP_MOVI);
`else
  logic            w_unused;
  assign w_movi   = 1'b0;
  assign w_unused = ^instr[2:0];
`endif

  assign instr_ready = (r_state == S_IDLE) & ~reset;
  assign w_accept    = instr_valid & instr_ready;
  assign dbg_data    = r_regs[dbg_addr];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Decode of the latched opcode into writeback / psr / illegal controls
  always_comb begin
    w_wr_en   = 1'b0;
    w_psr_all = 1'b0;
    w_psr_cmp = 1'b0;
    w_illegal = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_wr_en   = 1'b1;
        w_psr_all = 1'b1;
      end
      OP_CMP: w_psr_cmp = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH: w_wr_en = 1'b1;
      default: w_illegal = 1'b1;
    endcase
    if (w_movi) begin
      w_wr_en   = 1'b1;
      w_illegal = 1'b0;
    end
  end

  // Instruction latch, ALU operand drive, result capture, status pulses and psr
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_result   <= '0;
      r_flag_cap <= '0;
      alu_rsrc   <= '0;
      alu_rdest  <= '0;
      alu_opcode <= IDLE_OP;
      psr        <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
`ifdef ALU_SEQ_MOVI_EN
      r_imm      <= '0;
`endif
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= instr[15:11];
            r_rd <= instr[10:7];
            r_rs <= instr[6:3];
`ifdef ALU_SEQ_MOVI_EN
            r_imm <= instr[6:0];
`endif
          end
        end
        S_READ: begin
          alu_rdest  <= r_regs[r_rd];
          alu_rsrc   <= r_regs[r_rs];
          alu_opcode <= w_movi ? IDLE_OP : r_op;
        end
        S_EXEC: begin
`ifdef ALU_SEQ_MOVI_EN
          r_result <= w_movi ? {{9{r_imm[6]}}, r_imm} : alu_out;
`else
          r_result <= alu_out;
`endif
          r_flag_cap <= alu_flags;
          alu_opcode <= IDLE_OP;
          done       <= 1'b1;
          illegal    <= w_illegal;
        end
        S_WB: begin
          // CMP leaves C and F alone: the ALU does not define them for CMP
          if (w_psr_all) begin
            psr <= r_flag_cap;
          end else if (w_psr_cmp) begin
            psr[FLG_L] <= r_flag_cap[FLG_L];
            psr[FLG_Z] <= r_flag_cap[FLG_Z];
            psr[FLG_N] <= r_flag_cap[FLG_N];
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: direct load only in IDLE, result writeback in WB
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if ((r_state == S_IDLE) && ld_en) begin
      r_regs[ld_addr] <= ld_data;
    end else if ((r_state == S_WB) && w_wr_en) begin
      r_regs[r_rd] <= r_result;
    end
  end

  // Branch condition evaluation from the latched psr
  always_comb begin
    cond_met = 1'b0;
    case (cond)
      4'd0:    cond_met = psr[FLG_Z];
      4'd1:    cond_met = ~psr[FLG_Z];
      4'd2:    cond_met = psr[FLG_C];
      4'd3:    cond_met = ~psr[FLG_C];
      4'd4:    cond_met = psr[FLG_L];
      4'd5:    cond_met = ~psr[FLG_L];
      4'd6:    cond_met = ~psr[FLG_N] & ~psr[FLG_Z];
      4'd7:    cond_met = psr[FLG_N] | psr[FLG_Z];
      4'd8:    cond_met = psr[FLG_F];
      4'd9:    cond_met = ~psr[FLG_F];
      4'd14:   cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

endmodule
